// File: rtl/if_axi_bridge.sv
// Fetch-side read bridge: turns one simple-bus fetch request into a single-beat
// AXI4 read and returns the lane-aligned beat with a one-cycle ready pulse.
module if_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_bridge_valid_i,
  input  logic [63:0] if_bridge_addr_i,
  input  logic [1:0]  if_bridge_size_i,
  input  logic        if_bridge_req_i,
  output logic        if_bridge_ready_o,
  output logic [63:0] if_bridge_data_read_o,
  output logic [1:0]  if_bridge_resp_o,
  output logic        ar_valid_o,
  input  logic        ar_ready_i,
  output logic [63:0] ar_addr_o,
  output logic [3:0]  ar_id_o,
  output logic [7:0]  ar_len_o,
  output logic [2:0]  ar_size_o,
  output logic [1:0]  ar_burst_o,
  input  logic        r_valid_i,
  output logic        r_ready_o,
  input  logic [63:0] r_data_i,
  input  logic [1:0]  r_resp_i,
  input  logic        r_last_i
);

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned DATA_W      = 64;
  localparam logic        REQ_READ    = 1'b0;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_ar_valid;
  logic              r_r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic [5:0]        w_shift;
  logic              w_unused_last;

  // Single beat (len 0), so the last flag carries no information.
  assign w_unused_last = r_last_i;
  assign w_shift       = {r_addr[2:0], 3'b000};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_size     <= '0;
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
      r_data     <= '0;
      r_resp     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_bridge_valid_i) begin
            r_addr <= if_bridge_addr_i;
            r_size <= if_bridge_size_i;
            if (if_bridge_req_i == REQ_READ) begin
              r_ar_valid <= 1'b1;
              r_state    <= S_AR;
            end else begin
              // Illegal request type: answer locally, never touch AXI.
              r_data  <= '0;
              r_resp  <= RESP_SLVERR;
              r_state <= S_DONE;
            end
          end
        end
        S_AR: begin
          if (ar_ready_i) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_R;
          end
        end
        S_R: begin
          if (r_valid_i) begin
            r_r_ready <= 1'b0;
            r_data    <= r_data_i >> w_shift;
            r_resp    <= r_resp_i;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Deliver only if the fetch stage still wants this exact address.
  assign if_bridge_ready_o = (r_state == S_DONE) && if_bridge_valid_i &&
                             (if_bridge_addr_i == r_addr);

  assign if_bridge_data_read_o = r_data;
  assign if_bridge_resp_o      = r_resp;
  assign ar_valid_o            = r_ar_valid;
  assign ar_addr_o             = r_addr;
  assign ar_id_o               = AXI_ID;
  assign ar_len_o              = 8'd0;
  assign ar_size_o             = {1'b0, r_size};
  assign ar_burst_o            = BURST_INCR;
  assign r_ready_o             = r_r_ready;

endmodule

// File: tb/tb_if_axi_bridge.sv
// Randomized bench for if_axi_bridge: fetch-side driver, AXI slave model with
// configurable wait states, and a transaction-level expectation model.
module tb_if_axi_bridge;

  localparam logic [3:0] AXI_ID   = 4'h5;
  localparam logic       REQ_READ = 1'b0;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
  } ar_t;

  logic        clk, rst;
  logic        valid, req;
  logic [63:0] addr;
  logic [1:0]  size;
  logic        ready;
  logic [63:0] dout;
  logic [1:0]  resp;
  logic        ar_valid_o, ar_ready;
  logic [63:0] ar_addr_o;
  logic [3:0]  ar_id_o;
  logic [7:0]  ar_len_o;
  logic [2:0]  ar_size_o;
  logic [1:0]  ar_burst_o;
  logic        r_valid, r_ready_o, r_last;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  if_axi_bridge #(.AXI_ID(AXI_ID)) dut (
    .clk(clk), .rst(rst),
    .if_bridge_valid_i(valid), .if_bridge_addr_i(addr),
    .if_bridge_size_i(size), .if_bridge_req_i(req),
    .if_bridge_ready_o(ready), .if_bridge_data_read_o(dout),
    .if_bridge_resp_o(resp),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr_o),
    .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .ar_burst_o(ar_burst_o),
    .r_valid_i(r_valid), .r_ready_o(r_ready_o), .r_data_i(r_data),
    .r_resp_i(r_resp), .r_last_i(r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lane(input logic [63:0] beat, input logic [63:0] a);
    int sh;
    sh = 8 * int'(a[2:0]);
    return beat >> sh;
  endfunction

  // Slave configuration and observations shared with the driver.
  int          cfg_ar_d = 0, cfg_r_d = 0, cfg_resp = -1;
  bit          cfg_early = 0, cfg_fix = 0, slv_flush = 0;
  logic [63:0] cfg_data = '0;
  logic [63:0] beat_data = '0;
  logic [1:0]  beat_resp = '0;
  int          ar_hs_cnt = 0, r_hs_cnt = 0;
  ar_t         exp_ar_q[$];

  task automatic raise_beat();
    int pick;
    r_valid = 1'b1;
    r_last  = 1'b1;
    r_data  = cfg_fix ? cfg_data : {$urandom, $urandom};
    if (cfg_resp >= 0) r_resp = 2'(cfg_resp);
    else begin
      pick = int'($urandom_range(0, 3));
      r_resp = (pick < 2) ? 2'b00 : (pick == 2 ? 2'b10 : 2'b11);
    end
    beat_data = r_data;
    beat_resp = r_resp;
  endtask

  // AXI slave model; handshakes are inferred from values held across each edge.
  initial begin
    int          ar_wait, r_wait;
    bit          r_pend, last_arv, last_rr;
    logic [63:0] last_addr;
    logic [2:0]  last_size;
    ar_t         e;
    ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; r_data = '0; r_resp = '0;
    ar_wait = 0; r_wait = 0; r_pend = 0; last_arv = 0; last_rr = 0;
    last_addr = '0; last_size = '0;
    forever begin
      @(negedge clk);
      if (slv_flush) begin
        slv_flush = 0; ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0;
        r_pend = 0; last_arv = 0; last_rr = 0;
      end else begin
        chk("ar_r_excl", 64'(ar_valid_o & r_ready_o), 64'd0);
        if (ar_valid_o) begin
          chk("ar_len", 64'(ar_len_o), 64'd0);
          chk("ar_burst", 64'(ar_burst_o), 64'd1);
          chk("ar_id", 64'(ar_id_o), 64'(AXI_ID));
        end
        if (last_arv && !ar_ready) begin
          chk("ar_hold", 64'(ar_valid_o), 64'd1);
          chk("ar_addr_stable", ar_addr_o, last_addr);
          chk("ar_size_stable", 64'(ar_size_o), 64'(last_size));
        end
        if (last_arv && ar_ready) begin
          ar_hs_cnt++;
          if (exp_ar_q.size() == 0) chk("ar_extra", 64'd1, 64'd0);
          else begin
            e = exp_ar_q.pop_front();
            chk("ar_addr", last_addr, e.addr);
            chk("ar_size", 64'(last_size), 64'({1'b0, e.size}));
          end
          ar_ready = 1'b0; r_pend = 1; r_wait = cfg_r_d;
        end
        if (last_rr && r_valid) begin
          r_hs_cnt++; r_valid = 1'b0; r_last = 1'b0; r_pend = 0;
        end
        if (ar_valid_o && !last_arv) ar_wait = cfg_ar_d;
        if (ar_valid_o) begin
          if (ar_wait == 0) begin
            ar_ready = 1'b1;
            if (cfg_early && !r_valid) raise_beat();
          end else ar_wait--;
        end
        if (r_pend && !r_valid) begin
          if (r_wait == 0) raise_beat();
          else r_wait--;
        end
        last_arv = ar_valid_o; last_rr = r_ready_o;
        last_addr = ar_addr_o; last_size = ar_size_o;
      end
    end
  end

  task automatic set_cfg(input int ard, input int rd, input bit early);
    cfg_ar_d = ard; cfg_r_d = rd; cfg_early = early;
  endtask

  task automatic start_read(input logic [63:0] a, input logic [1:0] sz);
    ar_t e;
    e.addr = a; e.size = sz;
    exp_ar_q.push_back(e);
    valid = 1'b1; addr = a; size = sz; req = REQ_READ;
  endtask

  // Returns the number of cycles until ready (cycle of request = 0), or -1.
  task automatic wait_ready(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (ready) begin lat = i; break; end
    end
  endtask

  task automatic wait_sig(input bit use_ar, input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = use_ar ? ar_valid_o : r_ready_o;
    end
    if (!seen) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic check_reset_outs(input string p);
    chk({p, "_ar_valid"}, 64'(ar_valid_o), 64'd0);
    chk({p, "_r_ready"}, 64'(r_ready_o), 64'd0);
    chk({p, "_ready"}, 64'(ready), 64'd0);
    chk({p, "_data"}, dout, 64'd0);
    chk({p, "_resp"}, 64'(resp), 64'd0);
    chk({p, "_ar_addr"}, ar_addr_o, 64'd0);
    chk({p, "_ar_size"}, 64'(ar_size_o), 64'd0);
    chk({p, "_ar_id"}, 64'(ar_id_o), 64'(AXI_ID));
    chk({p, "_ar_len"}, 64'(ar_len_o), 64'd0);
    chk({p, "_ar_burst"}, 64'(ar_burst_o), 64'd1);
  endtask

  task automatic do_normal(input logic [63:0] a, input logic [1:0] sz, input int ard,
                           input int rd, input bit early);
    int lat;
    set_cfg(ard, rd, early);
    @(negedge clk);
    start_read(a, sz);
    wait_ready(60, lat);
    if (lat < 0) chk("rd_ready", 64'd0, 64'd1);
    else begin
      chk("rd_lat", 64'(lat), 64'(3 + ard + (early ? 0 : rd)));
      chk("rd_data", dout, lane(beat_data, a));
      chk("rd_resp", 64'(resp), 64'(beat_resp));
    end
    valid = 1'b0;
  endtask

  task automatic do_withdraw(input logic [63:0] a, input bit in_ar);
    int ar0, r0;
    set_cfg(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'($urandom));
    @(negedge clk);
    ar0 = ar_hs_cnt; r0 = r_hs_cnt;
    start_read(a, 2'b10);
    wait_sig(in_ar, "wd_wait");
    valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("wd_noready", 64'(ready), 64'd0);
    end
    chk("wd_ar_done", 64'(ar_hs_cnt - ar0), 64'd1);
    chk("wd_r_done", 64'(r_hs_cnt - r0), 64'd1);
  endtask

  task automatic do_change(input logic [63:0] a);
    int ar0, lat;
    ar_t e;
    logic [63:0] b;
    b = a ^ 64'h300;
    set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom));
    @(negedge clk);
    ar0 = ar_hs_cnt;
    start_read(a, 2'b10);
    wait_sig(1'b1, "chg_wait");
    e.addr = b; e.size = 2'b10;
    exp_ar_q.push_back(e);
    addr = b;
    wait_ready(80, lat);
    if (lat < 0) chk("chg_ready", 64'd0, 64'd1);
    else begin
      chk("chg_data", dout, lane(beat_data, b));
      chk("chg_resp", 64'(resp), 64'(beat_resp));
      chk("chg_ar_cnt", 64'(ar_hs_cnt - ar0), 64'd2);
    end
    valid = 1'b0;
  endtask

  task automatic do_nonread(input logic [63:0] a);
    int ar0, lat;
    @(negedge clk);
    ar0 = ar_hs_cnt;
    valid = 1'b1; addr = a; size = 2'b10; req = ~REQ_READ;
    wait_ready(10, lat);
    chk("nr_lat", 64'(lat), 64'd1);
    chk("nr_data", dout, 64'd0);
    chk("nr_resp", 64'(resp), 64'd2);
    valid = 1'b0; req = REQ_READ;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("nr_no_ar", 64'(ar_valid_o), 64'd0);
    end
    chk("nr_ar_cnt", 64'(ar_hs_cnt - ar0), 64'd0);
  endtask

  task automatic do_reset_in_r(input logic [63:0] a);
    set_cfg(0, 3, 1'b0);
    @(negedge clk);
    start_read(a, 2'b11);
    wait_sig(1'b0, "rst_wait");
    rst = 1'b0; slv_flush = 1; valid = 1'b0;
    @(negedge clk);
    check_reset_outs("rstr");
    rst = 1'b1;
    do_normal({$urandom, $urandom}, 2'b10, 0, 0, 1'b0);
  endtask

  initial begin
    int kind;
    rst = 1'b0; valid = 1'b0; req = REQ_READ; addr = '0; size = '0;
    repeat (3) @(negedge clk);
    check_reset_outs("rst0");
    rst = 1'b1;

    cfg_fix = 1; cfg_data = 64'h1234_5678_9ABC_DEF0; cfg_resp = 0;
    do_normal(64'h8000_0004, 2'b10, 0, 0, 1'b0);
    chk("basic_lo", 64'(dout[31:0]), 64'h1234_5678);
    do_normal(64'h8000_0000, 2'b10, 4, 0, 1'b0);
    chk("stall_lo", 64'(dout[31:0]), 64'h9ABC_DEF0);
    do_normal(64'h8000_0010, 2'b10, 0, 0, 1'b1);
    chk("early_lo", 64'(dout[31:0]), 64'h9ABC_DEF0);
    cfg_fix = 0;
    do_withdraw(64'h8000_0020, 1'b0);
    do_normal(64'h8000_0008, 2'b10, 0, 0, 1'b0);
    do_change(64'h100);
    cfg_resp = 2;
    do_normal(64'h8000_0006, 2'b01, 1, 2, 1'b0);
    chk("err_resp", 64'(resp), 64'd2);
    cfg_resp = -1;
    do_nonread(64'h8000_0040);
    do_reset_in_r(64'h8000_0080);

    for (int t = 0; t < 50; t++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 5)
        do_normal({$urandom, $urandom}, 2'($urandom), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 3)), 1'($urandom));
      else if (kind < 7) do_withdraw({$urandom, $urandom}, 1'($urandom));
      else if (kind == 7) do_change({$urandom, $urandom});
      else if (kind == 8) do_nonread({$urandom, $urandom});
      else do_reset_in_r({$urandom, $urandom});
    end

    repeat (4) @(negedge clk);
    chk("ar_q_empty", 64'(exp_ar_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
